// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed registers, independent write/read FSMs, flat reg_q export.
// Define AXI_REG_SLAVE_ERR_RESP_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi_lite_reg_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int RESP_WIDTH = 3,
   parameter int NUM_REGS   = 8
) (
   input  logic                           s_axi_aclk,
   input  logic                           s_axi_areset,
   input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
   input  logic                           s_axi_awvalid,
   output logic                           s_axi_awready,
   input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
   input  logic [DATA_WIDTH/8:0]          s_axi_wstrb,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   output logic [RESP_WIDTH-1:0]          s_axi_bresp,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
   input  logic                           s_axi_arvalid,
   output logic                           s_axi_arready,
   output logic [DATA_WIDTH-1:0]          s_axi_rdata,
   output logic [RESP_WIDTH-1:0]          s_axi_rresp,
   output logic                           s_axi_rvalid,
   input  logic                           s_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);
   // state  | meaning
   // W_IDLE | collecting AW and W halves in any order
   // W_RESP | write committed, bvalid held until bready
   // R_IDLE | arready high, waiting for AR
   // R_DATA | rvalid held with captured rdata/rresp until rready
   localparam int STRB_W = DATA_WIDTH/8;
   localparam int IDX_W  = ADDR_WIDTH-2;
   localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [RESP_WIDTH-1:0] RESP_OKAY = '0;
`ifdef AXI_REG_SLAVE_ERR_RESP_EN
   localparam logic [RESP_WIDTH-1:0] RESP_OOR = RESP_WIDTH'(2);
`else
   localparam logic [RESP_WIDTH-1:0] RESP_OOR = '0;
`endif

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t                 w_state, w_state_nxt;
   r_state_t                 r_state, r_state_nxt;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
   logic                     aw_got, aw_got_nxt, w_got, w_got_nxt;
   logic [IDX_W-1:0]         aw_idx_q, aw_idx_nxt;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_nxt;
   logic [STRB_W-1:0]        wstrb_q, wstrb_nxt;
   logic                     awready_nxt, wready_nxt, arready_nxt;
   logic [RESP_WIDTH-1:0]    bresp_nxt, rresp_nxt;
   logic [DATA_WIDTH-1:0]    rdata_nxt;
   logic                     commit;
   logic                     aw_hs, w_hs, ar_hs;
   logic [IDX_W-1:0]         ar_idx;
   logic                     unused_bits;

   function automatic logic in_range(input logic [IDX_W-1:0] idx);
      return {1'b0, idx} < (IDX_W+1)'(NUM_REGS);
   endfunction

   assign aw_hs  = s_axi_awvalid && s_axi_awready;
   assign w_hs   = s_axi_wvalid && s_axi_wready;
   assign ar_hs  = s_axi_arvalid && s_axi_arready;
   assign ar_idx = s_axi_araddr[ADDR_WIDTH-1:2];
   assign s_axi_bvalid = (w_state == W_RESP);
   assign s_axi_rvalid = (r_state == R_DATA);
   assign reg_q        = regs;
   // strobe MSB and the byte-offset address bits carry no meaning here
   assign unused_bits  = ^{s_axi_wstrb[STRB_W], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   always_comb begin
      w_state_nxt = w_state;
      aw_got_nxt  = aw_got;
      w_got_nxt   = w_got;
      aw_idx_nxt  = aw_idx_q;
      wdata_nxt   = wdata_q;
      wstrb_nxt   = wstrb_q;
      awready_nxt = 1'b0;
      wready_nxt  = 1'b0;
      bresp_nxt   = s_axi_bresp;
      commit      = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (aw_hs) begin
               aw_got_nxt = 1'b1;
               aw_idx_nxt = s_axi_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
               w_got_nxt = 1'b1;
               wdata_nxt = s_axi_wdata;
               wstrb_nxt = s_axi_wstrb[STRB_W-1:0];
            end
            if (aw_got_nxt && w_got_nxt) begin
               commit      = 1'b1;
               aw_got_nxt  = 1'b0;
               w_got_nxt   = 1'b0;
               w_state_nxt = W_RESP;
               bresp_nxt   = in_range(aw_idx_nxt) ? RESP_OKAY : RESP_OOR;
            end else begin
               awready_nxt = !aw_got_nxt;
               wready_nxt  = !w_got_nxt;
            end
         end
         W_RESP: if (s_axi_bready) w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_nxt = r_state;
      arready_nxt = s_axi_arready;
      rdata_nxt   = s_axi_rdata;
      rresp_nxt   = s_axi_rresp;
      case (r_state)
         R_IDLE: begin
            arready_nxt = 1'b1;
            if (ar_hs) begin
               arready_nxt = 1'b0;
               r_state_nxt = R_DATA;
               rdata_nxt   = in_range(ar_idx) ? regs[ar_idx[SEL_W-1:0]] : '0;
               rresp_nxt   = in_range(ar_idx) ? RESP_OKAY : RESP_OOR;
            end
         end
         R_DATA: begin
            if (s_axi_rready) begin
               r_state_nxt = R_IDLE;
               arready_nxt = 1'b1;
            end
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         w_state       <= W_IDLE;
         r_state       <= R_IDLE;
         aw_got        <= 1'b0;
         w_got         <= 1'b0;
         aw_idx_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_arready <= 1'b0;
         s_axi_bresp   <= '0;
         s_axi_rresp   <= '0;
         s_axi_rdata   <= '0;
      end else begin
         w_state       <= w_state_nxt;
         r_state       <= r_state_nxt;
         aw_got        <= aw_got_nxt;
         w_got         <= w_got_nxt;
         aw_idx_q      <= aw_idx_nxt;
         wdata_q       <= wdata_nxt;
         wstrb_q       <= wstrb_nxt;
         s_axi_awready <= awready_nxt;
         s_axi_wready  <= wready_nxt;
         s_axi_arready <= arready_nxt;
         s_axi_bresp   <= bresp_nxt;
         s_axi_rresp   <= rresp_nxt;
         s_axi_rdata   <= rdata_nxt;
      end
   end

   // reads sample regs combinationally, so a same-edge read sees the pre-commit value
   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         regs <= '0;
      end else if (commit && in_range(aw_idx_nxt)) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_nxt[b]) regs[aw_idx_nxt[SEL_W-1:0]][b*8 +: 8] <= wdata_nxt[b*8 +: 8];
         end
      end
   end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave (default parameters); expected out-of-range
// responses follow AXI_REG_SLAVE_ERR_RESP_EN.
module tb_axi_lite_reg_slave;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   awaddr = '0, araddr = '0;
   logic         awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
   logic [31:0]  wdata = '0;
   logic [4:0]   wstrb = '0;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [2:0]   bresp, rresp;
   logic [31:0]  rdata;
   logic [255:0] reg_q;
   int           n_checks = 0, n_errors = 0;
   logic [2:0]   resp;
   logic [31:0]  data;

`ifdef AXI_REG_SLAVE_ERR_RESP_EN
   localparam logic [2:0] OOR_RESP = 3'b010;
`else
   localparam logic [2:0] OOR_RESP = 3'b000;
`endif

   always #5 clk = ~clk;

   axi_lite_reg_slave dut (
      .s_axi_aclk(clk), .s_axi_areset(rst),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .reg_q(reg_q)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // AW and W presented together; bready assumed high
   task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                            output logic [2:0] r);
      logic aw_pend, w_pend, aw_fire, w_fire;
      int n;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
      aw_pend = 1; w_pend = 1; n = 0;
      while ((aw_pend || w_pend) && n < 20) begin
         aw_fire = aw_pend && awready;
         w_fire  = w_pend && wready;
         tick();
         if (aw_fire) begin awvalid = 0; aw_pend = 0; end
         if (w_fire)  begin wvalid = 0;  w_pend = 0;  end
         n++;
      end
      awvalid = 0; wvalid = 0;
      chk("wr_handshake_timeout", {aw_pend, w_pend}, 2'b00);
      chk("wr_bvalid_latency", bvalid, 1'b1);
      r = bresp;
      tick();
      chk("wr_bvalid_drop", bvalid, 1'b0);
   endtask

   task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] r);
      int n;
      araddr = a; arvalid = 1; n = 0;
      while (!arready && n < 20) begin tick(); n++; end
      chk("rd_arready_timeout", arready, 1'b1);
      tick();
      arvalid = 0;
      chk("rd_rvalid_latency", rvalid, 1'b1);
      d = rdata; r = rresp;
      tick();
      chk("rd_rvalid_drop", rvalid, 1'b0);
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_ready", {awready, wready, arready}, 3'b000);
      chk("rst_valid", {bvalid, rvalid}, 2'b00);
      chk("rst_resp_data", {bresp, rresp, rdata}, '0);
      chk("rst_reg_q", reg_q, '0);
      tick(); tick();
      rst = 0;
      chk("rel_ready_before_edge", {awready, wready, arready}, 3'b000);
      tick();
      chk("rel_ready_first_edge", {awready, wready, arready}, 3'b111);

      // basic write/read
      axi_write(8'h00, 32'h0000_0017, 5'h0F, resp);
      chk("wr0_bresp", resp, 3'b000);
      axi_read(8'h00, data, resp);
      chk("rd0_data", data, 32'h0000_0017);
      chk("rd0_rresp", resp, 3'b000);
      chk("reg_q0", reg_q[31:0], 32'h0000_0017);

      // byte strobes
      axi_write(8'h04, 32'h1122_3344, 5'h0F, resp);
      axi_write(8'h04, 32'hAABB_CCDD, 5'h01, resp);
      axi_read(8'h04, data, resp);
      chk("rd1_strb_merge", data, 32'h1122_33DD);
      axi_write(8'h0C, 32'hFFFF_FFFF, 5'h10, resp);
      chk("wstrb_msb_ignored", reg_q[127:96], 32'h0);
      axi_read(8'h06, data, resp);
      chk("addr_low_bits_ignored", data, 32'h1122_33DD);

      // W ahead of AW
      wdata = 32'h0000_005A; wstrb = 5'h0F; wvalid = 1;
      chk("w_first_wready", wready, 1'b1);
      tick();
      wvalid = 0;
      chk("w_first_wready_drop", wready, 1'b0);
      tick();
      chk("w_first_no_bvalid", {wready, bvalid}, 2'b00);
      awaddr = 8'h08; awvalid = 1;
      chk("w_first_awready", awready, 1'b1);
      tick();
      awvalid = 0;
      chk("w_first_bvalid", {bvalid, bresp}, {1'b1, 3'b000});
      chk("w_first_reg2", reg_q[95:64], 32'h0000_005A);
      tick();

      // out-of-range
      axi_write(8'h20, 32'hDEAD_BEEF, 5'h0F, resp);
      chk("oor_bresp", resp, OOR_RESP);
      chk("oor_no_change", reg_q, {160'h0, 32'h0000_005A, 32'h1122_33DD, 32'h0000_0017});
      axi_read(8'h20, data, resp);
      chk("oor_rdata", data, 32'h0);
      chk("oor_rresp", resp, OOR_RESP);

      // bready stall with concurrent read
      bready = 0;
      tick();
      awaddr = 8'h10; wdata = 32'h1234_5678; wstrb = 5'h0F; awvalid = 1; wvalid = 1;
      chk("stall_readies", {awready, wready}, 2'b11);
      tick();
      awvalid = 0; wvalid = 0;
      chk("stall_c1", {bvalid, awready, wready}, 3'b100);
      araddr = 8'h00; arvalid = 1;
      chk("stall_arready", arready, 1'b1);
      tick();
      arvalid = 0;
      chk("stall_c2", {bvalid, awready, wready, rvalid}, 4'b1001);
      chk("stall_rdata", {rdata, rresp}, {32'h0000_0017, 3'b000});
      tick();
      chk("stall_c3", {bvalid, awready, wready, rvalid}, 4'b1000);
      bready = 1;
      tick();
      chk("stall_bvalid_drop", {bvalid, awready}, 2'b00);
      tick();
      chk("stall_awready_back", {awready, wready}, 2'b11);
      chk("stall_reg4", reg_q[159:128], 32'h1234_5678);

      // reset mid-transaction
      bready = 0; rready = 0;
      awaddr = 8'h00; wdata = 32'h0; wstrb = 5'h0F; awvalid = 1; wvalid = 1;
      araddr = 8'h04; arvalid = 1;
      tick();
      awvalid = 0; wvalid = 0; arvalid = 0;
      chk("mid_both_pending", {bvalid, rvalid}, 2'b11);
      rst = 1;
      #1;
      chk("mid_valids_cleared", {bvalid, rvalid}, 2'b00);
      chk("mid_regs_cleared", reg_q, '0);
      tick();
      rst = 0; bready = 1; rready = 1;
      chk("mid_rel_ready_low", {awready, wready, arready}, 3'b000);
      tick();
      chk("mid_rel_ready_high", {awready, wready, arready}, 3'b111);
      axi_write(8'h1C, 32'hCAFE_F00D, 5'h0F, resp);
      chk("post_rst_bresp", resp, 3'b000);
      axi_read(8'h1C, data, resp);
      chk("post_rst_rdata", data, 32'hCAFE_F00D);
      chk("post_rst_reg_q", reg_q, {32'hCAFE_F00D, 224'h0});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
